// File: rtl/vram_loader_pkg.sv
// Shared types and default sizing for the stream-to-data-RAM loader.
package vram_loader_pkg;

    localparam int N_DEFAULT     = 8;      // bits per lane
    localparam int R_DEFAULT     = 6;      // lanes per memory word
    localparam int A_DEFAULT     = 32;     // word address width
    localparam int WORDS_DEFAULT = 10930;  // data RAM depth in words

    localparam int LANE_IDX_W = $clog2(R_DEFAULT);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } loader_state_t;

endpackage

// File: rtl/vram_byte_packer.sv
// Collects bytes into an R-lane word; lane 0 receives the first byte.
module vram_byte_packer
    import vram_loader_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int R = R_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                accept,
    input  logic [N-1:0]        byte_in,
    output logic [R-1:0][N-1:0] word_out,
    output logic                last_lane
);

    localparam int IDX_W = (R > 1) ? $clog2(R) : 1;

    logic [IDX_W-1:0] idx;

    assign last_lane = (idx == IDX_W'(R - 1));

    // Lane register and write index; clear restarts packing at lane 0.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            word_out <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (accept) begin
            word_out[idx] <= byte_in;
            idx           <= last_lane ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/vram_loader.sv
// Byte stream to data RAM writer: packs R bytes per word, writes consecutive
// word addresses, suppresses writes beyond WORDS and flags them in err.
// Optional: define VRAM_LOADER_CHECKSUM_EN to add an N-bit byte-sum output.
module vram_loader
    import vram_loader_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int R     = R_DEFAULT,
    parameter int A     = A_DEFAULT,
    parameter int WORDS = WORDS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [A-1:0]        base_addr,
    input  logic [A-1:0]        num_words,
    input  logic                s_valid,
    input  logic [N-1:0]        s_data,
    output logic                s_ready,
    output logic                mem_we,
    output logic [A-1:0]        mem_addr,
    output logic [R-1:0][N-1:0] mem_wd,
    output logic                busy,
    output logic                done,
    output logic                err
`ifdef VRAM_LOADER_CHECKSUM_EN
    ,
    output logic [N-1:0]        checksum
`endif
);

    loader_state_t state_q, state_d;

    logic [A-1:0]        base_q, num_q, count_q, addr_hold, cur_addr;
    logic [R-1:0][N-1:0] lanes, wd_hold;
    logic                last_lane, start_acc, xfer, in_range, in_write;

    assign start_acc = (state_q == IDLE) && start;
    assign xfer      = (state_q == FILL) && s_valid;
    assign in_write  = (state_q == WRITE);
    assign cur_addr  = base_q + count_q;
    assign in_range  = (cur_addr < A'(WORDS));

    vram_byte_packer #(.N(N), .R(R)) u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_acc || in_write),
        .accept   (xfer),
        .byte_in  (s_data),
        .word_out (lanes),
        .last_lane(last_lane)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and status outputs.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        mem_we  = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = (num_words == '0) ? DONE : FILL;
            end
            FILL: begin
                s_ready = 1'b1;
                if (s_valid && last_lane) state_d = WRITE;
            end
            WRITE: begin
                mem_we  = in_range;
                state_d = (count_q + A'(1) == num_q) ? DONE : FILL;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Load parameters, word counter and sticky out-of-range flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q  <= '0;
            num_q   <= '0;
            count_q <= '0;
            err     <= 1'b0;
        end else if (start_acc) begin
            base_q  <= base_addr;
            num_q   <= num_words;
            count_q <= '0;
            err     <= 1'b0;
        end else if (in_write) begin
            count_q <= count_q + A'(1);
            if (!in_range) err <= 1'b1;
        end
    end

    // Address and data keep their last WRITE values while mem_we is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_hold <= '0;
            wd_hold   <= '0;
        end else if (in_write) begin
            addr_hold <= cur_addr;
            wd_hold   <= lanes;
        end
    end

    assign mem_addr = in_write ? cur_addr : addr_hold;
    assign mem_wd   = in_write ? lanes    : wd_hold;

`ifdef VRAM_LOADER_CHECKSUM_EN
    // Running byte sum of every accepted byte, restarted on each load.
    always_ff @(posedge clk) begin
        if (reset)          checksum <= '0;
        else if (start_acc) checksum <= '0;
        else if (xfer)      checksum <= checksum + s_data;
    end
`endif

endmodule

// File: tb/tb_vram_loader.sv
// Scoreboard bench for vram_loader: expected writes are queued as stimulus is
// driven and popped by a monitor whenever mem_we is seen.
module tb_vram_loader;

    localparam int N     = 8;
    localparam int R     = 6;
    localparam int A     = 32;
    localparam int WORDS = 10930;

    typedef struct packed {
        logic [A-1:0]   addr;
        logic [R*N-1:0] wd;
    } wr_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [A-1:0]        base_addr = '0;
    logic [A-1:0]        num_words = '0;
    logic                s_valid = 1'b0;
    logic [N-1:0]        s_data = '0;
    logic                s_ready, mem_we, busy, done, err;
    logic [A-1:0]        mem_addr;
    logic [R-1:0][N-1:0] mem_wd;
`ifdef VRAM_LOADER_CHECKSUM_EN
    logic [N-1:0]        checksum;
`endif

    wr_t      sb[$];
    int       checks = 0;
    int       fails = 0;
    int       done_count = 0;
    int       we_count = 0;
    logic [N-1:0] csum = '0;

    vram_loader #(.N(N), .R(R), .A(A), .WORDS(WORDS)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base_addr(base_addr),
        .num_words(num_words),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .busy     (busy),
        .done     (done),
        .err      (err)
`ifdef VRAM_LOADER_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        wr_t exp_w;
        if (done) done_count++;
        if (mem_we) begin
            we_count++;
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%0d wd=%h, required no write", mem_addr, mem_wd);
            end else begin
                exp_w = sb.pop_front();
                if (mem_addr !== exp_w.addr || mem_wd !== exp_w.wd) begin
                    fails++;
                    $display("FAIL write: got addr=%0d wd=%h, required addr=%0d wd=%h",
                             mem_addr, mem_wd, exp_w.addr, exp_w.wd);
                end
            end
        end
    end

    function automatic logic [R*N-1:0] word_of(input logic [N-1:0] first);
        logic [R*N-1:0] w;
        for (int i = 0; i < R; i++) w[i*N +: N] = first + N'(i);
        return w;
    endfunction

    function automatic void expect_write(input logic [A-1:0] addr, input logic [N-1:0] first);
        wr_t e;
        e.addr = addr;
        e.wd   = word_of(first);
        if (addr < A'(WORDS)) sb.push_back(e);
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic start_load(input logic [A-1:0] base, input logic [A-1:0] num);
        start = 1'b1; base_addr = base; num_words = num; csum = '0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_byte(input logic [N-1:0] b);
        int n = 0;
        s_valid = 1'b1; s_data = b;
        @(negedge clk);
        while (!s_ready && n < 50) begin @(negedge clk); n++; end
        if (!s_ready) begin
            checks++; fails++;
            $display("FAIL byte_accept_timeout: s_ready=%b, required 1", s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        csum = csum + b;
    endtask

    task automatic send_word(input logic [N-1:0] first, input bit stall);
        for (int i = 0; i < R; i++) begin
            push_byte(first + N'(i));
            if (stall && i < R - 1) begin
                @(negedge clk);
                checks++;
                if (s_ready !== 1'b1) begin
                    fails++; $display("FAIL s_ready_fill: got %b, required 1", s_ready);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done();
        int n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 200);
        checks++;
        if (done !== 1'b1) begin
            fails++; $display("FAIL done_timeout: done=%b, required 1", done);
        end
`ifdef VRAM_LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== csum) begin
            fails++; $display("FAIL checksum: got %h, required %h", checksum, csum);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sb.size() != 0) begin
            fails++; $display("FAIL %s_pending: got %0d writes outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks += 7;
        if (s_ready !== 1'b0) begin fails++; $display("FAIL rst_s_ready: got %b, required 0", s_ready); end
        if (mem_we !== 1'b0) begin fails++; $display("FAIL rst_mem_we: got %b, required 0", mem_we); end
        if (mem_addr !== '0) begin fails++; $display("FAIL rst_mem_addr: got %0d, required 0", mem_addr); end
        if (mem_wd !== '0) begin fails++; $display("FAIL rst_mem_wd: got %h, required 0", mem_wd); end
        if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b, required 0", done); end
        if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b, required 0", err); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_word();
        start_load(0, 1);
        @(negedge clk);
        checks += 2;
        if (s_ready !== 1'b1) begin fails++; $display("FAIL basic_s_ready: got %b, required 1", s_ready); end
        if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b, required 1", busy); end
        @(posedge clk); #1;
        expect_write(0, 8'h01);
        for (int i = 0; i < R; i++) push_byte(8'h01 + 8'(i));
        @(negedge clk);
        checks += 2;
        if (mem_we !== 1'b1) begin fails++; $display("FAIL basic_we_time: got %b, required 1", mem_we); end
        if (s_ready !== 1'b0) begin fails++; $display("FAIL basic_write_s_ready: got %b, required 0", s_ready); end
        @(negedge clk);
        checks += 4;
        if (done !== 1'b1) begin fails++; $display("FAIL basic_done_time: got %b, required 1", done); end
        if (mem_we !== 1'b0) begin fails++; $display("FAIL basic_we_single: got %b, required 0", mem_we); end
        if (mem_wd !== word_of(8'h01)) begin fails++; $display("FAIL basic_wd_hold: got %h, required %h", mem_wd, word_of(8'h01)); end
`ifdef VRAM_LOADER_CHECKSUM_EN
        if (checksum !== 8'h15) begin fails++; $display("FAIL basic_checksum: got %h, required 15", checksum); end
`else
        if (mem_addr !== '0) begin fails++; $display("FAIL basic_addr_hold: got %0d, required 0", mem_addr); end
`endif
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_end: got %b, required 0", busy); end
        if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: got %b, required 0", done); end
        @(posedge clk); #1;
        check_sb_empty("basic");
    endtask

    task automatic test_stalled_stream();
        int d0 = done_count;
        int w0 = we_count;
        start_load(100, 3);
        for (int k = 0; k < 3; k++) begin
            expect_write(100 + k, 8'h10 * 8'(k + 1));
            send_word(8'h10 * 8'(k + 1), 1'b1);
        end
        wait_done();
        checks += 2;
        if (done_count - d0 != 1) begin fails++; $display("FAIL stall_done_pulses: got %0d, required 1", done_count - d0); end
        if (we_count - w0 != 3) begin fails++; $display("FAIL stall_writes: got %0d, required 3", we_count - w0); end
        check_sb_empty("stall");
    endtask

    task automatic test_zero_length();
        int w0 = we_count;
        start_load(5, 0);
        @(negedge clk);
        checks += 3;
        if (done !== 1'b1) begin fails++; $display("FAIL zero_done: got %b, required 1", done); end
        if (s_ready !== 1'b0) begin fails++; $display("FAIL zero_s_ready: got %b, required 0", s_ready); end
        if (busy !== 1'b1) begin fails++; $display("FAIL zero_busy: got %b, required 1", busy); end
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy_end: got %b, required 0", busy); end
        if (we_count != w0) begin fails++; $display("FAIL zero_writes: got %0d, required 0", we_count - w0); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_word();
        start_load(50, 2);
        for (int i = 0; i < 3; i++) push_byte(8'hE0 + 8'(i));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks += 5;
        if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        if (s_ready !== 1'b0) begin fails++; $display("FAIL midrst_s_ready: got %b, required 0", s_ready); end
        if (mem_we !== 1'b0) begin fails++; $display("FAIL midrst_we: got %b, required 0", mem_we); end
        if (mem_addr !== '0) begin fails++; $display("FAIL midrst_addr: got %0d, required 0", mem_addr); end
        if (mem_wd !== '0) begin fails++; $display("FAIL midrst_wd: got %h, required 0", mem_wd); end
        @(posedge clk); #1;
        start_load(200, 1);
        expect_write(200, 8'hA1);
        send_word(8'hA1, 1'b0);
        wait_done();
        check_sb_empty("midrst");
    endtask

    task automatic test_bounds();
        int d0 = done_count;
        start_load(10928, 4);
        for (int k = 0; k < 4; k++) begin
            expect_write(10928 + k, 8'h30 + 8'(k * 8));
            send_word(8'h30 + 8'(k * 8), 1'b0);
            if (k == 2) begin
                @(negedge clk);
                checks += 2;
                if (mem_we !== 1'b0) begin fails++; $display("FAIL bounds_we_suppressed: got %b, required 0", mem_we); end
                if (err !== 1'b0) begin fails++; $display("FAIL bounds_err_early: got %b, required 0", err); end
                @(negedge clk);
                checks++;
                if (err !== 1'b1) begin fails++; $display("FAIL bounds_err_set: got %b, required 1", err); end
                @(posedge clk); #1;
            end
        end
        wait_done();
        checks += 2;
        if (err !== 1'b1) begin fails++; $display("FAIL bounds_err_sticky: got %b, required 1", err); end
        if (done_count - d0 != 1) begin fails++; $display("FAIL bounds_done_pulses: got %0d, required 1", done_count - d0); end
        check_sb_empty("bounds");
        start_load(0, 0);
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin fails++; $display("FAIL bounds_err_clear: got %b, required 0", err); end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_start_during_fill();
        start_load(300, 2);
        expect_write(300, 8'h50);
        expect_write(301, 8'h60);
        for (int i = 0; i < 3; i++) push_byte(8'h50 + 8'(i));
        start = 1'b1; base_addr = 900; num_words = 5;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 3; i < R; i++) push_byte(8'h50 + 8'(i));
        send_word(8'h60, 1'b0);
        wait_done();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL ignstart_busy: got %b, required 0", busy); end
        @(posedge clk); #1;
        check_sb_empty("ignstart");
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_stalled_stream();
        test_zero_length();
        test_reset_mid_word();
        test_bounds();
        test_start_during_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
